// File: rtl/qos_priority_scheduler.sv
// Two-class QoS dispatcher: matched descriptors to a high queue, others to a low queue,
// drained by strict priority through a registered valid/ready stage. Optional starvation
// guard enabled by defining QOS_STARVE_GUARD_EN.

module qos_sched_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

module qos_priority_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_match,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_prio,
  output logic [DEPTH_LOG2:0]   hi_count,
  output logic [DEPTH_LOG2:0]   lo_count,
  output logic [15:0]           drop_hi_cnt,
  output logic [15:0]           drop_lo_cnt
);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..255");
  end

  logic [DATA_WIDTH-1:0] hi_rdata, lo_rdata;
  logic                  hi_full, lo_full, hi_ne, lo_ne;
  logic                  push_hi, push_lo, drop_hi, drop_lo;
  logic                  load, force_lo, grant_hi, grant_lo, pop_hi, pop_lo;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_prio_q, out_prio_d;
  logic [15:0]           drop_hi_q, drop_hi_d, drop_lo_q, drop_lo_d;

  // Full/empty are taken from start-of-cycle occupancy: a same-cycle pop never frees
  // room for a push, and a same-cycle push is never eligible for a pop.
  assign hi_full = (hi_count == FULL);
  assign lo_full = (lo_count == FULL);
  assign hi_ne   = (hi_count != '0);
  assign lo_ne   = (lo_count != '0);

  assign push_hi = in_valid &  in_match & ~hi_full;
  assign push_lo = in_valid & ~in_match & ~lo_full;
  assign drop_hi = in_valid &  in_match &  hi_full;
  assign drop_lo = in_valid & ~in_match &  lo_full;

  assign load     = ~out_valid_q | out_ready;
  assign grant_hi = hi_ne & ~force_lo;
  assign grant_lo = ~grant_hi & lo_ne;
  assign pop_hi   = load & grant_hi;
  assign pop_lo   = load & grant_lo;

`ifdef QOS_STARVE_GUARD_EN
  logic [7:0] starve_q, starve_d;

  assign force_lo = lo_ne && (starve_q == 8'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!lo_ne)      starve_d = '0;
    else if (pop_lo) starve_d = '0;
    else if (pop_hi) starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_lo = 1'b0;
`endif

  qos_sched_queue #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_hi (
    .clk(clk), .rst(rst), .push_i(push_hi), .pop_i(pop_hi), .wdata_i(in_data),
    .rdata_o(hi_rdata), .count_o(hi_count)
  );

  qos_sched_queue #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_lo (
    .clk(clk), .rst(rst), .push_i(push_lo), .pop_i(pop_lo), .wdata_i(in_data),
    .rdata_o(lo_rdata), .count_o(lo_count)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_prio_d  = out_prio_q;
    if (load) begin
      out_valid_d = grant_hi | grant_lo;
      if (grant_hi) begin
        out_data_d = hi_rdata;
        out_prio_d = 1'b1;
      end else if (grant_lo) begin
        out_data_d = lo_rdata;
        out_prio_d = 1'b0;
      end
    end
  end

  always_comb begin
    drop_hi_d = drop_hi_q;
    drop_lo_d = drop_lo_q;
    if (drop_hi && drop_hi_q != 16'hFFFF) drop_hi_d = drop_hi_q + 16'd1;
    if (drop_lo && drop_lo_q != 16'hFFFF) drop_lo_d = drop_lo_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prio_q  <= 1'b0;
      drop_hi_q   <= '0;
      drop_lo_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prio_q  <= out_prio_d;
      drop_hi_q   <= drop_hi_d;
      drop_lo_q   <= drop_lo_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_prio    = out_prio_q;
  assign drop_hi_cnt = drop_hi_q;
  assign drop_lo_cnt = drop_lo_q;
endmodule

// File: tb/tb_qos_priority_scheduler.sv
// Directed bench for qos_priority_scheduler: reset, latency, priority, backpressure,
// starvation guard (either build), overflow drops and drop-counter saturation.

module tb_qos_priority_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_match, out_ready;
  logic [31:0] in_data;
  logic        out_valid, out_prio;
  logic [31:0] out_data;
  logic [3:0]  hi_count, lo_count;
  logic [15:0] drop_hi_cnt, drop_lo_cnt;

  int n_chk = 0;
  int n_fail = 0;

  qos_priority_scheduler #(.DATA_WIDTH(32), .DEPTH_LOG2(3), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_match(in_match), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_prio(out_prio),
    .hi_count(hi_count), .lo_count(lo_count),
    .drop_hi_cnt(drop_hi_cnt), .drop_lo_cnt(drop_lo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] d);
    in_valid = 1'b1;
    in_match = m;
    in_data  = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_match = 1'b0;
    in_data  = '0;
  endtask

  // Consumer is ready: check the presented beat, then let it transfer.
  task automatic expect_out(input string tag, input logic [31:0] d, input logic p);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, out_data, d);
    chk({tag, " prio"}, 32'(out_prio), 32'(p));
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"}, out_data, 32'd0);
    chk({tag, " out_prio"}, 32'(out_prio), 32'd0);
    chk({tag, " hi_count"}, 32'(hi_count), 32'd0);
    chk({tag, " lo_count"}, 32'(lo_count), 32'd0);
    chk({tag, " drop_hi"}, 32'(drop_hi_cnt), 32'd0);
    chk({tag, " drop_lo"}, 32'(drop_lo_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    #12;
    rst = 1'b0;
    tick();

    // Reset mid-traffic, between clock edges
    push(1'b1, 32'h1); tick();
    push(1'b0, 32'h2); tick();
    push(1'b1, 32'h3); tick();
    idle();
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    #1 rst = 1'b0;
    push(1'b1, 32'h0A000001);
    tick();
    idle();
    chk("lat edge0 valid", 32'(out_valid), 32'd0);
    chk("lat edge0 hi_count", 32'(hi_count), 32'd1);
    tick();
    chk("lat edge1 hi_count", 32'(hi_count), 32'd0);
    out_ready = 1'b1;
    expect_out("lat", 32'h0A000001, 1'b1);
    chk("lat drained", 32'(out_valid), 32'd0);

    // Strict priority behind a blocker held in the output stage
    out_ready = 1'b0;
    push(1'b0, 32'hFF); tick();
    push(1'b0, 32'h10); tick();
    push(1'b0, 32'h11); tick();
    push(1'b0, 32'h12); tick();
    push(1'b1, 32'h20); tick();
    push(1'b1, 32'h21); tick();
    push(1'b1, 32'h22); tick();
    idle();
    chk("prio hi_count", 32'(hi_count), 32'd3);
    chk("prio lo_count", 32'(lo_count), 32'd3);
    out_ready = 1'b1;
    expect_out("prio blk", 32'hFF, 1'b0);
    expect_out("prio h0", 32'h20, 1'b1);
    expect_out("prio h1", 32'h21, 1'b1);
    expect_out("prio h2", 32'h22, 1'b1);
    expect_out("prio l0", 32'h10, 1'b0);
    expect_out("prio l1", 32'h11, 1'b0);
    expect_out("prio l2", 32'h12, 1'b0);
    chk("prio drained", 32'(out_valid), 32'd0);

    // Backpressure: output held stable for 5 stalled cycles
    out_ready = 1'b0;
    push(1'b1, 32'hA1); tick();
    push(1'b1, 32'hA2); tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold data", out_data, 32'hA1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp next data", out_data, 32'hA2);
    chk("bp next valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp drained", 32'(out_valid), 32'd0);

    // Starvation guard: 8 high + 2 low queued behind a blocker
    out_ready = 1'b0;
    push(1'b0, 32'hB0); tick();
    for (int i = 0; i < 8; i++) begin
      push(1'b1, 32'h30 + 32'(i)); tick();
    end
    push(1'b0, 32'h40); tick();
    push(1'b0, 32'h41); tick();
    idle();
    chk("guard hi_count", 32'(hi_count), 32'd8);
    chk("guard lo_count", 32'(lo_count), 32'd2);
    out_ready = 1'b1;
    expect_out("guard blk", 32'hB0, 1'b0);
`ifdef QOS_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) expect_out("guard h", 32'h30 + 32'(i), 1'b1);
    expect_out("guard l0", 32'h40, 1'b0);
    for (int i = 4; i < 8; i++) expect_out("guard h", 32'h30 + 32'(i), 1'b1);
    expect_out("guard l1", 32'h41, 1'b0);
`else
    for (int i = 0; i < 8; i++) expect_out("strict h", 32'h30 + 32'(i), 1'b1);
    expect_out("strict l0", 32'h40, 1'b0);
    expect_out("strict l1", 32'h41, 1'b0);
`endif
    chk("guard drained", 32'(out_valid), 32'd0);

    // Overflow: 10 high pushes with a stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(1'b1, 32'h50 + 32'(i)); tick();
    end
    chk("ovf hi_count", 32'(hi_count), 32'd8);
    chk("ovf drop_hi", 32'(drop_hi_cnt), 32'd1);
    chk("ovf out_data", out_data, 32'h50);
    // Push while full and popping in the same cycle is still dropped
    push(1'b1, 32'h5F);
    out_ready = 1'b1;
    tick();
    idle();
    chk("ovf pop-full drop_hi", 32'(drop_hi_cnt), 32'd2);
    chk("ovf pop-full hi_count", 32'(hi_count), 32'd7);
    for (int i = 1; i < 9; i++) expect_out("ovf drain", 32'h50 + 32'(i), 1'b1);
    chk("ovf drained", 32'(out_valid), 32'd0);
    chk("ovf drop_lo untouched", 32'(drop_lo_cnt), 32'd0);

    // Low drop counter saturation
    out_ready = 1'b0;
    push(1'b0, 32'h77);
    for (int i = 0; i < 65543; i++) tick();
    chk("sat 0xFFFE", 32'(drop_lo_cnt), 32'hFFFE);
    tick();
    chk("sat 0xFFFF", 32'(drop_lo_cnt), 32'hFFFF);
    for (int i = 0; i < 4465; i++) tick();
    idle();
    chk("sat held", 32'(drop_lo_cnt), 32'hFFFF);
    chk("sat lo_count", 32'(lo_count), 32'd8);
    chk("sat drop_hi", 32'(drop_hi_cnt), 32'd2);

    #2 rst = 1'b1;
    #1 chk_all_zero("final_rst");
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
